lcl_mmio_arbiter: RTL and testbench
===================================

LCL_MMIO_ARBITER -- requirements
Module: lcl_mmio_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024 (range 2..65535), meaning the downstream response wait limit in clk cycles.
REQ-002 SHALL have ports: clk  in  1  sole clock; rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have, for requester x in {a,b}: x_wr  in  1  write request level; x_rd  in  1  read request level; x_addr  in  32  address; x_din  in  32  write data.
REQ-004 SHALL have, per requester: x_ack  out  1  write-done pulse; x_dv  out  1  read-done pulse; x_rsp  out  1  0 good/1 bad, valid with ack/dv; x_dout  out  32  read data, valid with dv.
REQ-005 SHALL have downstream ports: lcl_mmio_wr  out  1; lcl_mmio_rd  out  1; lcl_mmio_addr  out  32; lcl_mmio_din  out  32; lcl_mmio_ack  in  1; lcl_mmio_rsp  in  1; lcl_mmio_dout  in  32; lcl_mmio_dv  in  1.
REQ-006 SHALL have status ports: busy  out  1  FSM not IDLE; timeout_cnt  out  16  saturating count of timeouts.

Function
REQ-007 Requester protocol: x_wr or x_rd held high, with x_addr/x_din stable, until the matching x_ack/x_dv pulse; the arbiter SHALL sample x_addr/x_din at grant.
REQ-008 If x_wr and x_rd are both high, SHALL serve it as a write; the read SHALL be ignored.
REQ-009 States: IDLE, ISSUE, WAIT, DONE, STALE.
REQ-010 IDLE: on any request, SHALL grant and latch addr/din/op into registers, then go to ISSUE next cycle.
REQ-011 Arbitration: single requester wins; both requesting SHALL grant the requester not granted last (round-robin); last_grant resets to b, so a wins the first tie.
REQ-012 ISSUE: SHALL pulse lcl_mmio_wr or lcl_mmio_rd for exactly one cycle with latched addr/din, then go to WAIT.
REQ-013 lcl_mmio_addr/lcl_mmio_din SHALL stay driven from latched registers from ISSUE until return to IDLE.
REQ-014 WAIT, write: on lcl_mmio_ack, SHALL register rsp and go to DONE; WAIT, read: on lcl_mmio_dv, SHALL register rsp and dout, then go to DONE.
REQ-015 WAIT: a response of the wrong type (ack during read, dv during write) SHALL be ignored.
REQ-016 DONE: SHALL pulse the granted requester's x_ack (write) or x_dv (read) for one cycle with registered x_rsp/x_dout, update last_grant, go to IDLE.
REQ-017 Latency, uncontended: request seen in IDLE cycle N -> lcl_mmio_wr/rd in cycle N+1; downstream response in cycle M -> requester pulse in cycle M+1.
REQ-018 Timeout: the wait counter SHALL clear in ISSUE and increment each WAIT cycle; reaching TIMEOUT_CYCLES without a response SHALL go to DONE with rsp=1, dout=0, and increment timeout_cnt (saturating at 16'hFFFF).
REQ-019 After a timeout DONE, SHALL enter STALE instead of IDLE; STALE SHALL discard one late ack/dv, or wait up to TIMEOUT_CYCLES more, then go to IDLE; no grant occurs in STALE.
REQ-020 The non-granted requester's ack/dv SHALL stay 0; its request SHALL remain pending and be served next in IDLE.
REQ-021 A response arriving in the same cycle the counter reaches the limit SHALL win; no timeout is recorded.
REQ-022 Downstream ack/dv in IDLE/ISSUE/DONE SHALL be ignored.

Reset
REQ-023 On rst: state=IDLE; all pulse outputs 0; x_rsp/x_dout 0; lcl_mmio_addr/din 0; last_grant=b; wait counter 0; timeout_cnt 0; busy 0.
REQ-024 rst asserted mid-transaction SHALL abort it without any requester pulse; a later downstream response SHALL be ignored.

Structure
REQ-025 State encoding and the timeout counter width (16) SHALL live in shared package lcl_mmio_arb_pkg.
REQ-026 Round-robin selection SHALL be sub-module lcl_mmio_rr_sel (2-way, last_grant in, grant out, combinational).

Verification
REQ-027 a_wr addr 0x100 din 0xDEADBEEF, ack rsp=0 after 3 cycles -> lcl_mmio_wr 1 cycle after request; a_ack=1, a_rsp=0 1 cycle after ack.
REQ-028 a_rd and b_rd same cycle, reset state -> a served first, then b; b_dv with b_dout = downstream dout 0x12345678.
REQ-029 TIMEOUT_CYCLES=8, b_rd, no response -> b_dv with b_rsp=1, b_dout=0; timeout_cnt=1; late dv in STALE -> no pulse to a or b.
REQ-030 a_wr and a_rd both high -> only lcl_mmio_wr issued; a_ack pulses; a_dv stays 0.
REQ-031 rst pulsed while in WAIT -> outputs at reset values; subsequent ack ignored; new a_wr served normally.
REQ-032 Response in the exact cycle the counter hits the limit -> good completion; timeout_cnt unchanged.

Source files
------------

// File: rtl/lcl_mmio_arb_pkg.sv
// Shared definitions for the two-requester local MMIO arbiter: FSM state
// encoding, counter width, requester select values and a saturating helper.
package lcl_mmio_arb_pkg;

    // Width of both the per-transaction wait counter and the timeout tally
    localparam int TCNT_W = 16;

    // Requester select values; last_grant and grant use the same encoding
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_STALE = 3'd4
    } arb_state_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [TCNT_W-1:0] sat_inc(input logic [TCNT_W-1:0] v);
        return (v == {TCNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/lcl_mmio_rr_sel.sv
// Two-way round-robin selector. A lone requester always wins; on a tie the
// requester that was not granted last time wins.
module lcl_mmio_rr_sel
    import lcl_mmio_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_sel
);

    // Pick a winner from the current request levels and the previous grant
    always_comb begin
        gnt_valid = req_a | req_b;
        gnt_sel   = SEL_A;
        if (req_a && req_b) begin
            gnt_sel = ~last_grant;
        end else if (req_b) begin
            gnt_sel = SEL_B;
        end
    end

endmodule

// File: rtl/lcl_mmio_arbiter.sv
// Arbitrates two level-signalled MMIO requesters onto one downstream
// local MMIO port. One transaction is in flight at a time; a response that
// never arrives is closed out as a bad completion after TIMEOUT_CYCLES, and
// the arbiter then waits in STALE so a late response cannot be mistaken for
// the answer to the next transaction.
module lcl_mmio_arbiter
    import lcl_mmio_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        a_wr,
    input  logic        a_rd,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_din,
    output logic        a_ack,
    output logic        a_dv,
    output logic        a_rsp,
    output logic [31:0] a_dout,

    input  logic        b_wr,
    input  logic        b_rd,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_din,
    output logic        b_ack,
    output logic        b_dv,
    output logic        b_rsp,
    output logic [31:0] b_dout,

    output logic        lcl_mmio_wr,
    output logic        lcl_mmio_rd,
    output logic [31:0] lcl_mmio_addr,
    output logic [31:0] lcl_mmio_din,
    input  logic        lcl_mmio_ack,
    input  logic        lcl_mmio_rsp,
    input  logic [31:0] lcl_mmio_dout,
    input  logic        lcl_mmio_dv,

    output logic        busy,
    output logic [15:0] timeout_cnt
);

    // Counter value seen during the last permitted WAIT (or STALE) cycle
    localparam logic [TCNT_W-1:0] WAIT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t        state_reg, state_next;
    logic              last_grant_reg;
    logic              gnt_reg;
    logic              op_wr_reg;
    logic [31:0]       addr_reg;
    logic [31:0]       din_reg;
    logic [TCNT_W-1:0] wait_cnt_reg;
    logic              rsp_reg;
    logic [31:0]       dout_reg;
    logic              timed_out_reg;
    logic [TCNT_W-1:0] timeout_cnt_reg;

    logic gnt_valid;
    logic gnt_sel;
    logic resp_hit;
    logic wait_expired;

    lcl_mmio_rr_sel u_rr_sel (
        .req_a      (a_wr | a_rd),
        .req_b      (b_wr | b_rd),
        .last_grant (last_grant_reg),
        .gnt_valid  (gnt_valid),
        .gnt_sel    (gnt_sel)
    );

    // Only the response type matching the issued operation counts
    assign resp_hit     = op_wr_reg ? lcl_mmio_ack : lcl_mmio_dv;
    assign wait_expired = (wait_cnt_reg == WAIT_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Grant latching, wait counting and response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg  <= SEL_B;
            gnt_reg         <= SEL_A;
            op_wr_reg       <= 1'b0;
            addr_reg        <= '0;
            din_reg         <= '0;
            wait_cnt_reg    <= '0;
            rsp_reg         <= 1'b0;
            dout_reg        <= '0;
            timed_out_reg   <= 1'b0;
            timeout_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        // A write request takes precedence over a read
                        gnt_reg   <= gnt_sel;
                        op_wr_reg <= (gnt_sel == SEL_B) ? b_wr : a_wr;
                        addr_reg  <= (gnt_sel == SEL_B) ? b_addr : a_addr;
                        din_reg   <= (gnt_sel == SEL_B) ? b_din : a_din;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt_reg  <= '0;
                    timed_out_reg <= 1'b0;
                end
                ST_WAIT: begin
                    // A response in the final cycle beats the timeout
                    if (resp_hit) begin
                        rsp_reg <= lcl_mmio_rsp;
                        if (!op_wr_reg) begin
                            dout_reg <= lcl_mmio_dout;
                        end
                    end else if (wait_expired) begin
                        rsp_reg         <= 1'b1;
                        dout_reg        <= '0;
                        timed_out_reg   <= 1'b1;
                        timeout_cnt_reg <= sat_inc(timeout_cnt_reg);
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    last_grant_reg <= gnt_reg;
                    wait_cnt_reg   <= '0;
                end
                ST_STALE: begin
                    wait_cnt_reg <= wait_cnt_reg + 1'b1;
                end
                default: begin
                    wait_cnt_reg <= '0;
                end
            endcase
        end
    end

    // Next-state decision
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (gnt_valid) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (resp_hit || wait_expired) state_next = ST_DONE;
            ST_DONE:  state_next = timed_out_reg ? ST_STALE : ST_IDLE;
            ST_STALE: if (lcl_mmio_ack || lcl_mmio_dv || wait_expired) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state and latched transaction
    always_comb begin
        lcl_mmio_wr   = (state_reg == ST_ISSUE) &&  op_wr_reg;
        lcl_mmio_rd   = (state_reg == ST_ISSUE) && !op_wr_reg;
        lcl_mmio_addr = addr_reg;
        lcl_mmio_din  = din_reg;

        a_ack  = (state_reg == ST_DONE) && (gnt_reg == SEL_A) &&  op_wr_reg;
        a_dv   = (state_reg == ST_DONE) && (gnt_reg == SEL_A) && !op_wr_reg;
        b_ack  = (state_reg == ST_DONE) && (gnt_reg == SEL_B) &&  op_wr_reg;
        b_dv   = (state_reg == ST_DONE) && (gnt_reg == SEL_B) && !op_wr_reg;

        a_rsp  = (a_ack || a_dv) ? rsp_reg : 1'b0;
        b_rsp  = (b_ack || b_dv) ? rsp_reg : 1'b0;
        a_dout = a_dv ? dout_reg : 32'h0;
        b_dout = b_dv ? dout_reg : 32'h0;

        busy        = (state_reg != ST_IDLE);
        timeout_cnt = timeout_cnt_reg;
    end

endmodule

// File: tb/tb_lcl_mmio_arbiter.sv
// Self-checking bench for lcl_mmio_arbiter with TIMEOUT_CYCLES=8. Requester
// completions are predicted into a scoreboard queue when a request is driven
// and popped when the arbiter pulses ack/dv; cycle-level behaviour is checked
// inline by a table of single transactions and a few hand-written sequences.
module tb_lcl_mmio_arbiter;

    localparam int T = 8;

    logic        clk, rst;
    logic        a_wr, a_rd, b_wr, b_rd;
    logic [31:0] a_addr, a_din, b_addr, b_din;
    logic        a_ack, a_dv, a_rsp, b_ack, b_dv, b_rsp;
    logic [31:0] a_dout, b_dout;
    logic        lcl_mmio_wr, lcl_mmio_rd, lcl_mmio_ack, lcl_mmio_rsp, lcl_mmio_dv;
    logic [31:0] lcl_mmio_addr, lcl_mmio_din, lcl_mmio_dout;
    logic        busy;
    logic [15:0] timeout_cnt;

    lcl_mmio_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .a_wr(a_wr), .a_rd(a_rd), .a_addr(a_addr), .a_din(a_din),
        .a_ack(a_ack), .a_dv(a_dv), .a_rsp(a_rsp), .a_dout(a_dout),
        .b_wr(b_wr), .b_rd(b_rd), .b_addr(b_addr), .b_din(b_din),
        .b_ack(b_ack), .b_dv(b_dv), .b_rsp(b_rsp), .b_dout(b_dout),
        .lcl_mmio_wr(lcl_mmio_wr), .lcl_mmio_rd(lcl_mmio_rd),
        .lcl_mmio_addr(lcl_mmio_addr), .lcl_mmio_din(lcl_mmio_din),
        .lcl_mmio_ack(lcl_mmio_ack), .lcl_mmio_rsp(lcl_mmio_rsp),
        .lcl_mmio_dout(lcl_mmio_dout), .lcl_mmio_dv(lcl_mmio_dv),
        .busy(busy), .timeout_cnt(timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          who;
        bit          is_wr;
        bit          rsp;
        logic [31:0] dout;
    } sb_t;

    typedef struct {
        bit          who;      // 0 = a, 1 = b
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] din;
        int          d;        // WAIT cycles before the downstream response
        bit          rsp;
        logic [31:0] rdata;
        bit          wrong;    // hold a wrong-type response beforehand
        bit          exp_wr;   // expected downstream op and requester pulse kind
        bit          exp_rsp;
        logic [31:0] exp_dout;
    } vec_t;

    sb_t  sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   pulse_cnt = 0;
    int   cyc = 0;
    int   exp_tcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, req);
        end
    endtask

    // Advance one clock and check any requester pulse against the scoreboard
    task automatic tick();
        logic        got_who, got_wr, got_rsp;
        logic [31:0] got_dout;
        sb_t         e;
        @(posedge clk);
        #1;
        cyc++;
        if (a_ack | a_dv | b_ack | b_dv) begin
            pulse_cnt++;
            chk("one_pulse", 32'(a_ack) + 32'(a_dv) + 32'(b_ack) + 32'(b_dv), 32'd1);
            got_who  = b_ack | b_dv;
            got_wr   = a_ack | b_ack;
            got_rsp  = got_who ? b_rsp : a_rsp;
            got_dout = got_who ? b_dout : a_dout;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse cycle=%0d a_ack=%b a_dv=%b b_ack=%b b_dv=%b expected=none",
                         cyc, a_ack, a_dv, b_ack, b_dv);
            end else begin
                e = sb_q.pop_front();
                chk("pulse_who", 32'(got_who), 32'(e.who));
                chk("pulse_kind", 32'(got_wr), 32'(e.is_wr));
                chk("pulse_rsp", 32'(got_rsp), 32'(e.rsp));
                if (!e.is_wr) chk("pulse_dout", got_dout, e.dout);
            end
        end
    endtask

    task automatic drive_req(input bit who, input bit wr, input bit rd,
                             input logic [31:0] addr, input logic [31:0] din);
        if (who) begin
            b_wr = wr; b_rd = rd; b_addr = addr; b_din = din;
        end else begin
            a_wr = wr; a_rd = rd; a_addr = addr; a_din = din;
        end
    endtask

    task automatic drop_req(input bit who);
        if (who) begin
            b_wr = 1'b0; b_rd = 1'b0;
        end else begin
            a_wr = 1'b0; a_rd = 1'b0;
        end
    endtask

    task automatic push_exp(input bit who, input bit is_wr, input bit rsp, input logic [31:0] dout);
        sb_t e;
        e.who = who; e.is_wr = is_wr; e.rsp = rsp; e.dout = dout;
        sb_q.push_back(e);
    endtask

    // Expects ISSUE on the next cycle, answers after d WAIT cycles, checks
    // the requester pulse lands the cycle after the response, then releases.
    task automatic serve(input bit who, input bit exp_wr, input logic [31:0] addr,
                         input logic [31:0] din, input int d, input bit rsp,
                         input logic [31:0] rdata, input bit wrong);
        int p0;
        tick();
        chk("issue_wr", 32'(lcl_mmio_wr), 32'(exp_wr));
        chk("issue_rd", 32'(lcl_mmio_rd), 32'(!exp_wr));
        chk("issue_addr", lcl_mmio_addr, addr);
        chk("issue_din", lcl_mmio_din, din);
        tick();
        chk("issue_one_cycle", 32'({lcl_mmio_wr, lcl_mmio_rd}), 32'd0);
        chk("addr_held", lcl_mmio_addr, addr);
        if (wrong) begin
            lcl_mmio_rsp  = 1'b1;
            lcl_mmio_dout = 32'hFFFF_FFFF;
            if (exp_wr) lcl_mmio_dv = 1'b1;
            else        lcl_mmio_ack = 1'b1;
        end
        for (int k = 1; k < d; k++) tick();
        lcl_mmio_ack  = exp_wr;
        lcl_mmio_dv   = !exp_wr;
        lcl_mmio_rsp  = rsp;
        lcl_mmio_dout = rdata;
        p0 = pulse_cnt;
        tick();
        lcl_mmio_ack = 1'b0; lcl_mmio_dv = 1'b0; lcl_mmio_rsp = 1'b0; lcl_mmio_dout = '0;
        chk("resp_to_pulse", 32'(pulse_cnt - p0), 32'd1);
        drop_req(who);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        int   p0;

        vecs[0] = '{who:0, wr:1, rd:0, addr:32'h100, din:32'hDEADBEEF, d:3, rsp:0, rdata:0, wrong:0,
                    exp_wr:1, exp_rsp:0, exp_dout:0};
        vecs[1] = '{who:1, wr:1, rd:0, addr:32'h204, din:32'hCAFEF00D, d:1, rsp:1, rdata:0, wrong:0,
                    exp_wr:1, exp_rsp:1, exp_dout:0};
        vecs[2] = '{who:0, wr:0, rd:1, addr:32'h300, din:32'h0, d:2, rsp:0, rdata:32'hA5A50001, wrong:1,
                    exp_wr:0, exp_rsp:0, exp_dout:32'hA5A50001};
        vecs[3] = '{who:1, wr:0, rd:1, addr:32'h404, din:32'h0, d:5, rsp:1, rdata:32'h0BAD0BAD, wrong:1,
                    exp_wr:0, exp_rsp:1, exp_dout:32'h0BAD0BAD};
        vecs[4] = '{who:0, wr:1, rd:1, addr:32'h500, din:32'h11112222, d:2, rsp:0, rdata:0, wrong:1,
                    exp_wr:1, exp_rsp:0, exp_dout:0};
        vecs[5] = '{who:1, wr:0, rd:1, addr:32'h540, din:32'h0, d:T, rsp:0, rdata:32'h76543210, wrong:0,
                    exp_wr:0, exp_rsp:0, exp_dout:32'h76543210};
        vecs[6] = '{who:0, wr:1, rd:0, addr:32'h580, din:32'h55AA55AA, d:T, rsp:0, rdata:0, wrong:0,
                    exp_wr:1, exp_rsp:0, exp_dout:0};

        a_wr = 0; a_rd = 0; a_addr = 0; a_din = 0;
        b_wr = 0; b_rd = 0; b_addr = 0; b_din = 0;
        lcl_mmio_ack = 0; lcl_mmio_rsp = 0; lcl_mmio_dout = 0; lcl_mmio_dv = 0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tcnt", 32'(timeout_cnt), 32'd0);
        chk("rst_addr", lcl_mmio_addr, 32'd0);
        chk("rst_din", lcl_mmio_din, 32'd0);
        chk("rst_strobes", 32'({lcl_mmio_wr, lcl_mmio_rd, a_ack, a_dv, b_ack, b_dv}), 32'd0);
        chk("rst_rsp_dout", 32'(a_rsp) + 32'(b_rsp) + a_dout + b_dout, 32'd0);
        rst = 1'b0;
        tick();

        // Tie out of reset: a wins, b is served next with its read data
        drive_req(0, 0, 1, 32'h1000, 32'h0);
        drive_req(1, 0, 1, 32'h2000, 32'h0);
        push_exp(0, 0, 0, 32'hAAAA0000);
        push_exp(1, 0, 0, 32'h12345678);
        serve(0, 0, 32'h1000, 32'h0, 1, 0, 32'hAAAA0000, 0);
        tick();
        chk("tie_idle_between", 32'(busy), 32'd0);
        serve(1, 0, 32'h2000, 32'h0, 2, 0, 32'h12345678, 0);
        tick();
        chk("tie_done_idle", 32'(busy), 32'd0);

        // Single-requester table
        for (int i = 0; i < 7; i++) begin
            drive_req(vecs[i].who, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].din);
            push_exp(vecs[i].who, vecs[i].exp_wr, vecs[i].exp_rsp, vecs[i].exp_dout);
            serve(vecs[i].who, vecs[i].exp_wr, vecs[i].addr, vecs[i].din,
                  vecs[i].d, vecs[i].rsp, vecs[i].rdata, vecs[i].wrong);
            tick();
            chk("vec_idle", 32'(busy), 32'd0);
            chk("vec_tcnt", 32'(timeout_cnt), 32'(exp_tcnt));
            chk("vec_sb_empty", 32'(sb_q.size()), 32'd0);
        end

        // Timeout on a b read, then a late dv swallowed in STALE
        drive_req(1, 0, 1, 32'h3000, 32'h0);
        push_exp(1, 0, 1, 32'h0);
        tick();
        chk("to_issue_rd", 32'(lcl_mmio_rd), 32'd1);
        p0 = pulse_cnt;
        for (int k = 0; k < T; k++) tick();
        chk("to_no_early_pulse", 32'(pulse_cnt - p0), 32'd0);
        tick();
        exp_tcnt++;
        chk("to_pulse", 32'(pulse_cnt - p0), 32'd1);
        chk("to_tcnt", 32'(timeout_cnt), 32'(exp_tcnt));
        drop_req(1);
        tick();
        chk("stale_busy", 32'(busy), 32'd1);
        drive_req(0, 1, 0, 32'h600, 32'h6666);
        lcl_mmio_dv = 1'b1; lcl_mmio_rsp = 1'b0; lcl_mmio_dout = 32'h9999;
        p0 = pulse_cnt;
        tick();
        lcl_mmio_dv = 1'b0; lcl_mmio_dout = '0;
        chk("stale_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        chk("stale_no_grant", 32'({lcl_mmio_wr, busy}), 32'd0);
        push_exp(0, 1, 0, 32'h0);
        serve(0, 1, 32'h600, 32'h6666, 2, 0, 32'h0, 0);
        tick();
        chk("after_stale_idle", 32'(busy), 32'd0);
        chk("after_stale_tcnt", 32'(timeout_cnt), 32'(exp_tcnt));

        // Reset in WAIT aborts silently; later ack ignored; next request fine
        drive_req(0, 1, 0, 32'h700, 32'h7777);
        tick();
        tick();
        tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        exp_tcnt = 0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_addr", lcl_mmio_addr, 32'd0);
        chk("mid_rst_din", lcl_mmio_din, 32'd0);
        chk("mid_rst_tcnt", 32'(timeout_cnt), 32'(exp_tcnt));
        chk("mid_rst_strobes", 32'({a_ack, a_dv, b_ack, b_dv}), 32'd0);
        drop_req(0);
        p0 = pulse_cnt;
        tick();
        rst = 1'b0;
        lcl_mmio_ack = 1'b1;
        tick();
        lcl_mmio_ack = 1'b0;
        tick();
        chk("post_rst_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        chk("post_rst_idle", 32'(busy), 32'd0);
        drive_req(0, 1, 0, 32'h800, 32'h8888);
        push_exp(0, 1, 0, 32'h0);
        serve(0, 1, 32'h800, 32'h8888, 1, 0, 32'h0, 0);
        tick();
        chk("final_idle", 32'(busy), 32'd0);
        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
